// File: rtl/nn_layer_sequencer_pkg.sv
// nn_seq_pkg: shared state encoding, layer sizes and counter sizing for the MLP layer sequencer
package nn_seq_pkg;
  localparam int ADDR_W = 32;
  localparam int L1_INPUTS_DEF = 784;
  localparam int L2_INPUTS_DEF = 128;
  localparam int L3_INPUTS_DEF = 32;
  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_L1 = 2'd1;
  localparam logic [1:0] SEL_L2 = 2'd2;
  localparam logic [1:0] SEL_L3 = 2'd3;
  typedef enum logic [3:0] {
    S_IDLE, S_L1_FEED, S_L1_WAIT, S_L2_FEED, S_L2_WAIT,
    S_L3_FEED, S_L3_WAIT, S_SM_WAIT, S_DONE, S_ERR
  } state_t;
  // The feed counter also runs through the ROM drain cycles, so size it for the largest layer plus latency.
  function automatic int cnt_w(input int a, input int b, input int c, input int lat);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m + lat > 2 ? $clog2(m + lat) : 1;
  endfunction
endpackage

// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: host/datapath handshake bundle of the layer sequencer
interface nn_layer_sequencer_if;
  import nn_seq_pkg::*;
  logic start, abort;
  logic l1_done, l2_done, l3_done, sm_done;
  logic [ADDR_W-1:0] current_addr;
  logic l1_run, l2_run, l3_run;
  logic [1:0] layer_sel;
  logic busy, done, error;
  modport master (
    input start, abort, l1_done, l2_done, l3_done, sm_done,
    output current_addr, l1_run, l2_run, l3_run, layer_sel, busy, done, error
  );
  modport slave (
    output start, abort, l1_done, l2_done, l3_done, sm_done,
    input current_addr, l1_run, l2_run, l3_run, layer_sel, busy, done, error
  );
endinterface

// File: rtl/nn_layer_sequencer_watchdog.sv
// seq_watchdog: counts cycles spent in one wait state and flags the cycle that reaches TIMEOUT
module seq_watchdog #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear || !en ? '0 : cnt + 1'b1;
  assign expired = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: frame controller streaming addresses and run strobes through the three MLP layers
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int L1_INPUTS = L1_INPUTS_DEF,
  parameter int L2_INPUTS = L2_INPUTS_DEF,
  parameter int L3_INPUTS = L3_INPUTS_DEF,
  parameter int ROM_LAT = 1,
  parameter int TIMEOUT = 4095
) (
  input logic clk,
  input logic rst_n,
  nn_layer_sequencer_if.master bus
);
  localparam int CW = cnt_w(L1_INPUTS, L2_INPUTS, L3_INPUTS, ROM_LAT);
  localparam logic [CW-1:0] L1_N = CW'(L1_INPUTS);
  localparam logic [CW-1:0] L1_MAX = CW'(L1_INPUTS - 1);
  localparam logic [CW-1:0] L1_END = CW'(L1_INPUTS - 1 + ROM_LAT);
  localparam logic [CW-1:0] L2_END = CW'(L2_INPUTS - 1);
  localparam logic [CW-1:0] L3_END = CW'(L3_INPUTS - 1);
  state_t st, nx;
  logic [CW-1:0] cnt, lim, addr;
  logic [3:0] dn;
  logic feed, wait_st, issue, wd_exp, err_q;
  function automatic state_t await_nx(input logic [3:0] hit, input logic [3:0] want,
                                      input state_t go, input state_t cur, input logic exp);
    return (hit & ~want) != '0 ? S_ERR : (hit & want) != '0 ? go : exp ? S_ERR : cur;
  endfunction
  assign dn = {bus.sm_done, bus.l3_done, bus.l2_done, bus.l1_done};
  assign feed = st inside {S_L1_FEED, S_L2_FEED, S_L3_FEED};
  assign wait_st = st inside {S_L1_WAIT, S_L2_WAIT, S_L3_WAIT, S_SM_WAIT};
  assign lim = st == S_L1_FEED ? L1_END : st == S_L2_FEED ? L2_END : L3_END;
  assign issue = st == S_L1_FEED && cnt < L1_N;
  assign addr = st == S_L1_FEED ? (issue ? cnt : L1_MAX) : st inside {S_L2_FEED, S_L3_FEED} ? cnt : '0;
  always_comb begin
    nx = st;
    case (st)
      S_IDLE, S_ERR: nx = bus.start ? S_L1_FEED : st;
      S_L1_FEED, S_L2_FEED, S_L3_FEED:
        nx = |dn ? S_ERR : cnt != lim ? st :
             st == S_L1_FEED ? S_L1_WAIT : st == S_L2_FEED ? S_L2_WAIT : S_L3_WAIT;
      S_L1_WAIT: nx = await_nx(dn, 4'b0001, S_L2_FEED, st, wd_exp);
      S_L2_WAIT: nx = await_nx(dn, 4'b0010, S_L3_FEED, st, wd_exp);
      S_L3_WAIT: nx = await_nx(dn, 4'b0100, S_SM_WAIT, st, wd_exp);
      S_SM_WAIT: nx = await_nx(dn, 4'b1000, S_DONE, st, wd_exp);
      default: nx = S_IDLE;
    endcase
    if (bus.abort) nx = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      st <= nx;
      cnt <= nx == st && feed ? cnt + 1'b1 : '0;
      err_q <= nx == S_ERR ? 1'b1 : st inside {S_IDLE, S_ERR} && nx == S_L1_FEED ? 1'b0 : err_q;
    end
  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .rst_n(rst_n), .clear(nx != st), .en(wait_st), .expired(wd_exp)
  );
  // Image ROM data trails its address by ROM_LAT cycles, so l1_run is the issue flag delayed to match.
  if (ROM_LAT == 0) begin : g_direct
    assign bus.l1_run = issue;
  end else begin : g_pipe
    logic [ROM_LAT-1:0] sr;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '0;
      else sr <= nx == S_L1_FEED ? (sr << 1) | ROM_LAT'(issue) : '0;
    assign bus.l1_run = sr[ROM_LAT-1];
  end
  assign bus.current_addr = ADDR_W'(addr);
  assign bus.l2_run = st == S_L2_FEED;
  assign bus.l3_run = st == S_L3_FEED;
  assign bus.layer_sel = st inside {S_L1_FEED, S_L1_WAIT} ? SEL_L1 :
                         st inside {S_L2_FEED, S_L2_WAIT} ? SEL_L2 :
                         st inside {S_L3_FEED, S_L3_WAIT, S_SM_WAIT} ? SEL_L3 : SEL_IDLE;
  assign bus.busy = feed || wait_st;
  assign bus.done = st == S_DONE;
  assign bus.error = err_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: randomized frame-level checks of nn_layer_sequencer against a phase-arithmetic model
module tb_nn_layer_sequencer;
  localparam int N1 = 784, N2 = 128, N3 = 32;
  typedef struct packed {
    logic [31:0] addr;
    logic r1, r2, r3;
    logic [1:0] sel;
    logic busy, done, err;
  } snap_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0, ph_bad = 0;
  int first_t, last_t, runs;
  snap_t ph_o, ph_e;
  bit err_exp [2];
  nn_layer_sequencer_if ia ();
  nn_layer_sequencer_if ib ();
  nn_layer_sequencer #(.L1_INPUTS(N1), .L2_INPUTS(N2), .L3_INPUTS(N3), .ROM_LAT(1), .TIMEOUT(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  nn_layer_sequencer #(.L1_INPUTS(N1), .L2_INPUTS(N2), .L3_INPUTS(N3), .ROM_LAT(2), .TIMEOUT(16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  always #5 clk = ~clk;

  function automatic int lat(bit b);
    return b ? 2 : 1;
  endfunction
  function automatic snap_t snap(bit b);
    return b ? snap_t'{ib.current_addr, ib.l1_run, ib.l2_run, ib.l3_run, ib.layer_sel, ib.busy, ib.done, ib.error}
             : snap_t'{ia.current_addr, ia.l1_run, ia.l2_run, ia.l3_run, ia.layer_sel, ia.busy, ia.done, ia.error};
  endfunction
  function automatic snap_t mk(int addr, bit r1, bit r2, bit r3, int sel, bit busy, bit done, bit err);
    return snap_t'{32'(addr), r1, r2, r3, 2'(sel), busy, done, err};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask
  // s: 0 start, 1 abort, 2..4 l1..l3_done, 5 sm_done
  task automatic drv(bit b, int s, logic v);
    if (b)
      case (s)
        0: ib.start = v;
        1: ib.abort = v;
        2: ib.l1_done = v;
        3: ib.l2_done = v;
        4: ib.l3_done = v;
        default: ib.sm_done = v;
      endcase
    else
      case (s)
        0: ia.start = v;
        1: ia.abort = v;
        2: ia.l1_done = v;
        3: ia.l2_done = v;
        4: ia.l3_done = v;
        default: ia.sm_done = v;
      endcase
  endtask
  task automatic cyc(bit b, snap_t e);
    snap_t o;
    o = snap(b);
    if (o !== e) begin
      if (ph_bad == 0) begin
        ph_o = o;
        ph_e = e;
      end
      ph_bad++;
    end
  endtask
  task automatic ph_end(string tag);
    checks++;
    assert (ph_bad === 0) else begin
      errors++;
      $error("FAIL %s bad_cycles=%0d got=%h exp=%h", tag, ph_bad, ph_o, ph_e);
    end
    ph_bad = 0;
  endtask
  task automatic chk(string tag, int o, int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, o, e);
    end
  endtask
  task automatic idle(bit b, int n, string tag);
    repeat (n) begin
      cyc(b, mk(0, 0, 0, 0, 0, 0, 0, err_exp[b]));
      tick;
    end
    ph_end(tag);
  endtask
  task automatic start_frame(bit b);
    drv(b, 0, 1'b1);
    tick;
    drv(b, 0, 1'b0);
    err_exp[b] = 1'b0;
  endtask
  // act at stop_i: 1 abort+start, 2 stray l3_done, 3 asynchronous reset
  task automatic feed(bit b, int k, int n, int stop_i, int act, string tag);
    int l;
    l = k == 1 ? lat(b) : 0;
    runs = 0;
    first_t = -1;
    last_t = -1;
    for (int i = 0; i < n + l; i++) begin
      snap_t o;
      bit r;
      r = i >= l && i < n + l;
      cyc(b, mk(i < n ? i : n - 1, k == 1 && r, k == 2 && r, k == 3 && r, k, 1, 0, 0));
      o = snap(b);
      if ((k == 1 ? o.r1 : k == 2 ? o.r2 : o.r3) === 1'b1) begin
        runs++;
        if (first_t < 0) first_t = i + 1;
        last_t = i + 1;
      end
      if (i == stop_i) begin
        ph_end(tag);
        case (act)
          1: begin
            drv(b, 0, 1'b1);
            drv(b, 1, 1'b1);
            tick;
            drv(b, 0, 1'b0);
            drv(b, 1, 1'b0);
          end
          2: begin
            drv(b, 4, 1'b1);
            tick;
            drv(b, 4, 1'b0);
          end
          default: begin
            #2 rst_n = 1'b0;
            #1 cyc(b, mk(0, 0, 0, 0, 0, 0, 0, 0));
            ph_end({tag, "_async_rst"});
          end
        endcase
        return;
      end
      tick;
    end
    ph_end(tag);
    chk({tag, "_runs"}, runs, n);
    if (k == 1) begin
      chk({tag, "_first_run_offset"}, first_t, l + 1);
      chk({tag, "_last_run_offset"}, last_t, n + l);
    end
  endtask
  // k 1..3 layer waits, 4 softmax wait; d+1 wait cycles when the done pulse is given
  task automatic wait_ph(bit b, int k, int d, bit give, string tag);
    for (int j = 0; j < d; j++) begin
      cyc(b, mk(0, 0, 0, 0, k == 4 ? 3 : k, 1, 0, 0));
      tick;
    end
    if (give) begin
      cyc(b, mk(0, 0, 0, 0, k == 4 ? 3 : k, 1, 0, 0));
      drv(b, k + 1, 1'b1);
      tick;
      drv(b, k + 1, 1'b0);
    end
    ph_end(tag);
  endtask
  task automatic run_frame(bit b, string tag);
    start_frame(b);
    for (int k = 1; k <= 3; k++) begin
      feed(b, k, k == 1 ? N1 : k == 2 ? N2 : N3, -1, 0, $sformatf("%s_l%0d_feed", tag, k));
      wait_ph(b, k, $urandom_range(0, 7), 1, $sformatf("%s_l%0d_wait", tag, k));
    end
    wait_ph(b, 4, $urandom_range(0, 7), 1, {tag, "_sm_wait"});
    cyc(b, mk(0, 0, 0, 0, 0, 0, 1, err_exp[b]));
    drv(b, 0, 1'b1);
    tick;
    drv(b, 0, 1'b0);
    repeat (3) begin
      cyc(b, mk(0, 0, 0, 0, 0, 0, 0, err_exp[b]));
      tick;
    end
    ph_end({tag, "_done"});
  endtask

  initial begin
    for (int s = 0; s < 6; s++) begin
      drv(0, s, 1'b0);
      drv(1, s, 1'b0);
    end
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    tick;
    idle(0, 1, "reset_a");
    idle(1, 1, "reset_b");
    rst_n = 1'b1;
    tick;
    run_frame(0, "frame1");
    run_frame(0, "frame2");
    start_frame(1);
    feed(1, 1, N1, -1, 0, "b_l1_feed");
    wait_ph(1, 1, 3, 1, "b_l1_wait");
    feed(1, 2, N2, -1, 0, "b_l2_feed");
    drv(1, 1, 1'b1);
    tick;
    drv(1, 1, 1'b0);
    idle(1, 3, "b_abort_idle");
    start_frame(0);
    feed(0, 1, N1, -1, 0, "to_l1_feed");
    wait_ph(0, 1, 2, 1, "to_l1_wait");
    feed(0, 2, N2, -1, 0, "to_l2_feed");
    wait_ph(0, 2, 16, 0, "to_l2_wait16");
    err_exp[0] = 1'b1;
    idle(0, 3, "to_err");
    run_frame(0, "restart");
    start_frame(0);
    feed(0, 1, N1, 400, 1, "ab_l1_feed");
    idle(0, 6, "ab_idle");
    run_frame(0, "post_abort");
    start_frame(0);
    feed(0, 1, N1, -1, 0, "pe_l1_feed");
    wait_ph(0, 1, $urandom_range(0, 7), 1, "pe_l1_wait");
    feed(0, 2, N2, 50, 2, "pe_l2_feed");
    err_exp[0] = 1'b1;
    idle(0, 3, "pe_err");
    drv(0, 1, 1'b1);
    tick;
    drv(0, 1, 1'b0);
    idle(0, 2, "pe_abort_keeps_err");
    drv(0, 2, 1'b1);
    tick;
    drv(0, 2, 1'b0);
    idle(0, 4, "pe_idle_l1_done");
    run_frame(0, "post_err");
    start_frame(0);
    feed(0, 1, N1, -1, 0, "rs_l1_feed");
    wait_ph(0, 1, $urandom_range(0, 7), 1, "rs_l1_wait");
    feed(0, 2, N2, -1, 0, "rs_l2_feed");
    wait_ph(0, 2, $urandom_range(0, 7), 1, "rs_l2_wait");
    feed(0, 3, N3, 10, 3, "rs_l3_feed");
    tick;
    rst_n = 1'b1;
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    tick;
    idle(0, 3, "rs_idle");
    idle(1, 1, "rs_idle_b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
